serial_tx: RTL and testbench
============================

# serial_tx

Parallel-in, serial-out frame transmitter: the sending end of the team's single-wire serial link, paired with our serial-in register/receiver blocks. It accepts a WIDTH-bit word over a valid/ready handshake and sends one frame: start bit, data bits LSB first, an optional even-parity bit, then a stop bit. Each bit is held for CLKS_PER_BIT clock cycles. It sits between a parallel register stage and the line driver.

## Interface
- WIDTH, 4: data word width, ≥1.
- CLKS_PER_BIT, 4: clock cycles per serial bit, ≥1.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  word to send; sampled only on handshake.
- in_ready  output  1  transmitter can accept a word.
- tx_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States are IDLE, START, DATA, PARITY and STOP.
- Reset values: state IDLE, tx_out=1, busy=0, done=0, in_ready=1, shift register 0, bit counter 0, baud counter 0.
- in_ready = (state==IDLE). It is a combinational decode of the registered state.
- Handshake: a transfer occurs when in_valid && in_ready are both high at a rising edge. On that edge in_data loads into the shift register and the state goes to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then the state goes to DATA with bit counter 0.
- DATA: tx_out = shift[0]. After CLKS_PER_BIT cycles, the register shifts right and the bit counter increments. After WIDTH bits the state goes to PARITY if compiled in, otherwise to STOP.
- PARITY: tx_out = XOR of the latched word (even parity), for CLKS_PER_BIT cycles, then the state goes to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. done=1 on the final cycle. The state then returns to IDLE.
- busy=1 in every state except IDLE.
- tx_out, busy and done are registered outputs, with no combinational path from the inputs.
- The baud counter runs from 0 to CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- The bit counter width is $clog2(WIDTH+1).
- While busy, in_valid and in_data are ignored. An upstream source holding in_valid high is not consumed until in_ready returns.
- in_data changing after the handshake has no effect on the frame in flight.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. All outputs go to their reset values and no done pulse is issued.

## Timing
- Handshake at edge T: tx_out falls to 0 after edge T, and the start bit spans cycles T+1 to T+CLKS_PER_BIT.
- Frame length is F = (WIDTH+2)·CLKS_PER_BIT cycles, or (WIDTH+3)·CLKS_PER_BIT with parity.
- done is high in the cycle ending at edge T+F. IDLE and in_ready=1 follow in the next cycle.
- Back-to-back frames: the minimum spacing between handshakes is F+1 cycles, which leaves one idle-high cycle between frames.
- CLKS_PER_BIT=1 is legal: each bit lasts exactly one cycle.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state is compiled in and one even-parity bit is inserted between the data and stop bits.
- SERIAL_TX_PARITY_EN undefined: the PARITY state and the parity logic are absent, and DATA goes directly to STOP.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), sized to 3 bits;
  - the line levels LINE_IDLE=1'b1 and START_LVL=1'b0.
- One sub-module is natural: baud_tick. It takes CLKS_PER_BIT as a parameter and produces a one-cycle tick at each bit boundary. It is cleared when a frame starts and when in IDLE.
- Everything else stays in serial_tx.

## Test plan
- Reset check: apply rst_n=0, then release. Expect tx_out=1, in_ready=1, busy=0 and done=0, all stable with in_valid=0.
- Send 4'hA with WIDTH=4, CLKS_PER_BIT=4, no parity. Expect:
  - tx_out holds 0,0,1,0,1,1 (start, bits LSB first, stop), each for 4 cycles;
  - done pulses in the 24th cycle after the handshake;
  - in_ready rises the next cycle.
- With SERIAL_TX_PARITY_EN: send 4'hA, expect a parity bit of 0; send 4'h7, expect a parity bit of 1. Frame length is 28 cycles.
- Hold in_valid=1 and present 4'h3 then 4'hC. Expect:
  - the second word is accepted exactly one cycle after the first done;
  - a single idle-high cycle separates the frames;
  - in_data toggling mid-frame does not corrupt either frame.
- Assert rst_n low in the middle of the DATA bits. Expect tx_out=1 and busy=0 immediately, no done pulse, and a new handshake accepted after release.
- With CLKS_PER_BIT=1: send 4'h5. Expect tx_out = 0,1,0,1,0,1 on consecutive cycles and done in cycle 6.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM states and line levels for the serial link blocks
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/serial_tx_baud_tick.sv
// baud_tick: bit-boundary tick generator, held at zero while clr is high
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt, cnt_nxt;
  // pre_tick flags that the coming cycle is the last one of the current bit
  always_comb begin
    tick = !clr && cnt == LAST;
    cnt_nxt = (clr || tick) ? '0 : cnt + 1'b1;
    pre_tick = cnt_nxt == LAST;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: start/data(LSB first)/stop frame transmitter over valid/ready.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic tx_nxt, tick, pre_tick, last_bit;
  assign in_ready = state == IDLE;
  assign last_bit = bit_cnt == BW'(WIDTH - 1);
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst_n(rst_n), .clr(in_ready), .tick(tick), .pre_tick(pre_tick)
  );
`ifdef SERIAL_TX_PARITY_EN
  logic par;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) par <= 1'b0;
    else if (in_valid && in_ready) par <= ^in_data;
`endif
  // outputs are registered from the next-state view so they align with state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx_out  <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx_out  <= tx_nxt;
      busy    <= state_nxt != IDLE;
      done    <= state_nxt == STOP && pre_tick;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = START;
      START:  if (tick) state_nxt = DATA;
`ifdef SERIAL_TX_PARITY_EN
      DATA:   if (tick && last_bit) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
`else
      DATA:   if (tick && last_bit) state_nxt = STOP;
`endif
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    shift_nxt = (in_valid && in_ready) ? in_data : (state == DATA && tick) ? shift >> 1 : shift;
    bit_cnt_nxt = state != DATA ? '0 : tick ? bit_cnt + 1'b1 : bit_cnt;
    tx_nxt = state_nxt == START ? START_LVL : state_nxt == DATA ? shift_nxt[0] : LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
    if (state_nxt == PARITY) tx_nxt = par;
`endif
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed vector bench for serial_tx (CLKS_PER_BIT 4 and 1)
module tb_serial_tx;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int C = 4;
  localparam int F = (6 + PAR) * C;
  localparam int F1 = 6 + PAR;

  typedef struct {
    logic [3:0] data;
    logic [6:0] fr;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, tx_out, busy, done;
  logic [3:0] in_data = '0;
  logic v1 = 1'b0, r1, tx1, b1, dn1;
  logic [3:0] d1 = '0;
  int checks = 0, errors = 0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(4), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .done(done)
  );
  serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1),
    .in_ready(r1), .tx_out(tx1), .busy(b1), .done(dn1)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [6:0] fr, input int j);
    return (PAR == 0 && j == 5) ? fr[6] : fr[j];
  endfunction

  task automatic start(input logic [3:0] d);
    for (int i = 0; i < 200 && !in_ready; i++) @(posedge clk) #1;
    chk("ready_wait", {3'b0, in_ready}, 4'h1);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  // checks {tx_out,busy,done,in_ready} every cycle of a frame, then the idle cycle
  task automatic run_frame(input string name, input logic [6:0] fr, input logic [3:0] nxt);
    for (int k = 1; k <= F; k++) begin
      chk(name, {tx_out, busy, done, in_ready}, {bit_at(fr, (k - 1) / C), 1'b1, k == F, 1'b0});
      in_data = (k >= F - 1) ? nxt : 4'($urandom);
      @(posedge clk) #1;
    end
    chk({name, "_idle"}, {tx_out, busy, done, in_ready}, 4'b1001);
  endtask

  initial begin
    // frame bits, index 0=start, 1..4=data LSB first, 5=parity, 6=stop
    vecs[0] = '{4'hA, 7'b1010100};
    vecs[1] = '{4'h7, 7'b1101110};
    vecs[2] = '{4'h3, 7'b1000110};
    vecs[3] = '{4'h5, 7'b1001010};
    vecs[4] = '{4'hF, 7'b1011110};
    vecs[5] = '{4'h1, 7'b1100010};
    repeat (3) @(posedge clk);
    #1 chk("in_reset", {tx_out, busy, done, in_ready}, 4'b1001);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      chk("after_reset", {tx_out, busy, done, in_ready}, 4'b1001);
      chk("after_reset_c1", {tx1, b1, dn1, r1}, 4'b1001);
    end
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].data);
      run_frame($sformatf("frame_%h", vecs[i].data), vecs[i].fr, 4'h0);
    end
    in_valid = 1'b1;
    in_data = 4'h3;
    @(posedge clk) #1;
    run_frame("b2b_first", vecs[2].fr, 4'hC);
    @(posedge clk) #1;
    in_valid = 1'b0;
    run_frame("b2b_second", 7'b1011000, 4'h0);
    start(4'hA);
    repeat (2 * C + 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_async", {tx_out, busy, done, in_ready}, 4'b1001);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk) #1;
      chk("abort_hold", {tx_out, busy, done, in_ready}, 4'b1001);
    end
    #3 rst_n = 1'b1;
    @(posedge clk) #1;
    start(4'hF);
    run_frame("after_abort", vecs[4].fr, 4'h0);
    for (int i = 0; i < 50 && !r1; i++) @(posedge clk) #1;
    chk("c1_ready", {3'b0, r1}, 4'h1);
    v1 = 1'b1;
    d1 = 4'h5;
    @(posedge clk) #1;
    v1 = 1'b0;
    d1 = 4'hA;
    for (int k = 1; k <= F1; k++) begin
      chk("c1_frame", {tx1, b1, dn1, r1}, {bit_at(vecs[3].fr, k - 1), 1'b1, k == F1, 1'b0});
      @(posedge clk) #1;
    end
    chk("c1_idle", {tx1, b1, dn1, r1}, 4'b1001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
